fp_mul_packer: RTL and testbench

//  Back end of the FP32 multiplier: the inverse of the operand unpack stage.
//  - Takes sign, summed biased exponents and the 48-bit raw significand product.
//  - Normalizes, rounds to nearest-even and packs an IEEE-754 single result with flags.
//  - Multi-cycle, one operation in flight; valid/ready on both sides.

---
 rtl/fp_mul_packer.sv | 216 +++++++++++++++++++++
 tb/tb_fp_mul_packer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fp_mul_packer.sv
// fp_mul_packer: FP32 multiplier back end. Normalizes the raw significand
// product, rounds to nearest-even and packs an IEEE-754 single with flags.
// One operation in flight: IDLE -> NORM -> ROUND -> OUT.
// out_valid rises in the third cycle after the accept cycle.
// Build option: FPU_MUL_FTZ_EN flushes tiny results to signed zero and
// omits the denormalizing shifter. Without it, results underflow gradually.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        operand handshake (in_ready high only in IDLE)
//   sign_in, exp_sum           result sign, E_A + E_B (biased)
//   mant_prod                  M_A * M_B, hidden bits included
//   special_in, special_result upstream-resolved special case
//   out_valid / out_ready      result handshake
//   result                     packed {sign, exp, frac}
//   overflow, underflow, inexact   exception flags, held with result
module fp_mul_packer #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_in,
  input  logic [EXP_W:0]         exp_sum,
  input  logic [2*(MAN_W+1)-1:0] mant_prod,
  input  logic                   special_in,
  input  logic [EXP_W+MAN_W:0]   special_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);
  localparam int unsigned PW   = 2 * (MAN_W + 1);
  localparam int unsigned RW   = EXP_W + MAN_W + 1;
  localparam int unsigned EW   = EXP_W + 3;
  localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int unsigned EMAX = 2 ** EXP_W - 1;
  localparam int unsigned LZW  = $clog2(PW);
  localparam int unsigned SHW  = $clog2(MAN_W + 4);
  localparam int unsigned SMAX = MAN_W + 3;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
  state_t state;

  // operand registers (loaded on accept)
  logic              a_sign, a_spec;
  logic [EXP_W:0]    a_exp;
  logic [PW-1:0]     a_prod;
  logic [RW-1:0]     a_spec_res;

  // normalized registers (loaded in NORM); leading 1 sits at bit PW-2
  logic              n_sign, n_spec, n_zero, n_sticky, n_tiny;
  logic [RW-1:0]     n_spec_res;
  logic [PW-2:0]     n_mant;
  logic signed [EW-1:0] n_exp;

  // normalize: one-bit right shift or leading-zero left shift, then denormalize
  logic [LZW-1:0]       lz;
  logic signed [EW-1:0] e0, ne_c;
  logic [PW-2:0]        nm_c;
  logic                 ns_c, nt_c;
`ifndef FPU_MUL_FTZ_EN
  logic signed [EW-1:0] dsh;
  logic [SHW-1:0]       sh;
`endif

  always_comb begin
    lz   = '0;
    for (int i = 0; i < PW - 1; i++)
      if (a_prod[i]) lz = LZW'(PW - 2 - i);
    e0   = $signed(EW'(a_exp)) - $signed(EW'(BIAS));
    nm_c = a_prod[PW-2:0];
    ne_c = e0;
    ns_c = 1'b0;
    nt_c = 1'b0;
`ifndef FPU_MUL_FTZ_EN
    dsh  = '0;
    sh   = '0;
`endif
    if (a_prod[PW-1]) begin
      nm_c = a_prod[PW-1:1];
      ne_c = e0 + $signed(EW'(1));
      ns_c = a_prod[0];
    end else begin
      nm_c = (PW-1)'(a_prod << lz);
      ne_c = e0 - $signed(EW'(lz));
    end
    if (ne_c[EW-1] || ne_c == '0) begin
      nt_c = 1'b1;
`ifndef FPU_MUL_FTZ_EN
      dsh  = $signed(EW'(1)) - ne_c;
      sh   = (dsh > $signed(EW'(SMAX))) ? SHW'(SMAX) : dsh[SHW-1:0];
      ns_c = ns_c | (|(nm_c & ~({(PW-1){1'b1}} << sh)));
      nm_c = nm_c >> sh;
`endif
      ne_c = '0;
    end
  end

  // round to nearest-even and pack
  logic [MAN_W:0]       keep;
  logic [MAN_W+1:0]     sum;
  logic [MAN_W-1:0]     frac;
  logic signed [EW-1:0] re;
  logic                 guard, sticky, inc;
  logic [RW-1:0]        res_c;
  logic                 ov_c, uf_c, ix_c;

  always_comb begin
    keep   = n_mant[PW-2 -: MAN_W+1];
    guard  = n_mant[MAN_W-1];
    sticky = (|n_mant[MAN_W-2:0]) | n_sticky;
    inc    = guard & (sticky | keep[0]);
    sum    = {1'b0, keep} + (MAN_W+2)'(inc);
    re     = n_exp;
    if (sum[MAN_W+1]) begin
      frac = sum[MAN_W:1];
      re   = n_exp + $signed(EW'(1));
    end else begin
      frac = sum[MAN_W-1:0];
      // a subnormal that rounds up to 2**MAN_W becomes the smallest normal
      if (n_exp == '0 && sum[MAN_W]) re = $signed(EW'(1));
    end
    ix_c  = guard | sticky;
    ov_c  = 1'b0;
    uf_c  = n_tiny & ix_c;
    res_c = {n_sign, re[EXP_W-1:0], frac};
    if (n_spec) begin
      res_c = n_spec_res;
      ov_c  = 1'b0;
      uf_c  = 1'b0;
      ix_c  = 1'b0;
    end else if (n_zero) begin
      res_c = {n_sign, (RW-1)'(0)};
      uf_c  = 1'b0;
      ix_c  = 1'b0;
`ifdef FPU_MUL_FTZ_EN
    end else if (n_tiny) begin
      res_c = {n_sign, (RW-1)'(0)};
      uf_c  = 1'b1;
      ix_c  = 1'b1;
`endif
    end else if (re >= $signed(EW'(EMAX))) begin
      res_c = {n_sign, {EXP_W{1'b1}}, MAN_W'(0)};
      ov_c  = 1'b1;
      ix_c  = 1'b1;
      uf_c  = 1'b0;
    end
  end

  // control FSM with registered outputs and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      inexact    <= 1'b0;
      a_sign     <= 1'b0;
      a_spec     <= 1'b0;
      a_exp      <= '0;
      a_prod     <= '0;
      a_spec_res <= '0;
      n_sign     <= 1'b0;
      n_spec     <= 1'b0;
      n_zero     <= 1'b0;
      n_sticky   <= 1'b0;
      n_tiny     <= 1'b0;
      n_spec_res <= '0;
      n_mant     <= '0;
      n_exp      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_sign     <= sign_in;
          a_spec     <= special_in;
          a_exp      <= exp_sum;
          a_prod     <= mant_prod;
          a_spec_res <= special_result;
          in_ready   <= 1'b0;
          state      <= NORM;
        end
        NORM: begin
          n_sign     <= a_sign;
          n_spec     <= a_spec;
          n_zero     <= (a_prod == '0);
          n_spec_res <= a_spec_res;
          n_mant     <= nm_c;
          n_exp      <= ne_c;
          n_sticky   <= ns_c;
          n_tiny     <= nt_c;
          state      <= ROUND;
        end
        ROUND: begin
          result    <= res_c;
          overflow  <= ov_c;
          underflow <= uf_c;
          inexact   <= ix_c;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_packer.sv
// Directed bench for fp_mul_packer: vector table plus handshake/reset sequences.
module tb_fp_mul_packer;
`ifdef FPU_MUL_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        sign_in;
  logic [8:0]  exp_sum;
  logic [47:0] mant_prod;
  logic        special_in;
  logic [31:0] special_result;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_sum(exp_sum), .mant_prod(mant_prod),
    .special_in(special_in), .special_result(special_result),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  typedef struct {
    string       name;
    logic        s;
    logic [8:0]  es;
    logic [47:0] p;
    logic        sp;
    logic [31:0] sr;
    logic [31:0] res;
    logic [2:0]  fl;   // {overflow, underflow, inexact}
  } vec_t;

  vec_t v[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one bundle from a negedge; returns at the negedge where out_valid must be high.
  task automatic apply(input string nm, input logic s, input logic [8:0] es,
                       input logic [47:0] p, input logic sp, input logic [31:0] sr);
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    sign_in = s; exp_sum = es; mant_prod = p; special_in = sp; special_result = sr;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_lat3"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sign_in = 1'b0; exp_sum = '0; mant_prod = '0;
    special_in = 1'b0; special_result = '0; out_ready = 1'b1;

    v[0]  = '{"mul_1p5", 1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, 32'h0, 32'h40100000, 3'b000};
    v[1]  = '{"ovf_big", 1'b0, 9'd400, 48'h4000_0000_0000, 1'b0, 32'h0, 32'h7F800000, 3'b101};
    v[2]  = '{"tie_even_dn", 1'b0, 9'd254, 48'h4000_0040_0000, 1'b0, 32'h0, 32'h3F800000, 3'b001};
    v[3]  = '{"tie_even_up", 1'b0, 9'd254, 48'h4000_00C0_0000, 1'b0, 32'h0, 32'h3F800002, 3'b001};
    v[4]  = '{"subn_exact", 1'b0, 9'd126, 48'h4000_0000_0000, 1'b0, 32'h0,
              FTZ ? 32'h00000000 : 32'h00200000, FTZ ? 3'b011 : 3'b000};
    v[5]  = '{"special", 1'b0, 9'd400, 48'h4000_0000_0000, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000};
    v[6]  = '{"zero_neg", 1'b1, 9'd254, 48'h0, 1'b0, 32'h0, 32'h80000000, 3'b000};
    v[7]  = '{"neg_1p5", 1'b1, 9'd254, 48'h9000_0000_0000, 1'b0, 32'h0, 32'hC0100000, 3'b000};
    v[8]  = '{"subn_inexact", 1'b0, 9'd126, 48'h4000_0000_0001, 1'b0, 32'h0,
              FTZ ? 32'h00000000 : 32'h00200000, 3'b011};
    v[9]  = '{"left_shift", 1'b0, 9'd254, 48'h1000_0000_0000, 1'b0, 32'h0, 32'h3E800000, 3'b000};
    v[10] = '{"round_carry", 1'b0, 9'd254, 48'h7FFF_FFC0_0000, 1'b0, 32'h0, 32'h40000000, 3'b001};
    v[11] = '{"subn_to_norm", 1'b0, 9'd127, 48'h7FFF_FF80_0000, 1'b0, 32'h0,
              FTZ ? 32'h00000000 : 32'h00800000, 3'b011};
    v[12] = '{"ovf_edge", 1'b0, 9'd382, 48'h4000_0000_0000, 1'b0, 32'h0, 32'h7F800000, 3'b101};
    v[13] = '{"max_exp", 1'b0, 9'd381, 48'h4000_0000_0000, 1'b0, 32'h0, 32'h7F000000, 3'b000};
    v[14] = '{"deep_uflow", 1'b0, 9'd10, 48'h4000_0000_0000, 1'b0, 32'h0, 32'h00000000, 3'b011};

    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", 32'({overflow, underflow, inexact}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      apply(v[i].name, v[i].s, v[i].es, v[i].p, v[i].sp, v[i].sr);
      chk({v[i].name, "_result"}, result, v[i].res);
      chk({v[i].name, "_flags"}, 32'({overflow, underflow, inexact}), 32'(v[i].fl));
      @(posedge clk);
      @(negedge clk);
      chk({v[i].name, "_pop"}, 32'({out_valid, in_ready}), 32'b01);
    end

    // backpressure: result held, no new accept until out_ready
    out_ready = 1'b0;
    apply("hold", 1'b0, 9'd254, 48'h9000_0000_0000, 1'b1, 32'h7FC00000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_result", result, 32'h7FC00000);
      chk("hold_valid_ready", 32'({out_valid, in_ready}), 32'b10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release", 32'({out_valid, in_ready}), 32'b01);

    // reset during ROUND aborts the operation
    sign_in = 1'b0; exp_sum = 9'd254; mant_prod = 48'h9000_0000_0000; special_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);            // accept -> NORM
    #1 in_valid = 1'b0;
    @(posedge clk);            // -> ROUND
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
    end
    chk("abort_ready", 32'(in_ready), 32'd1);

    // block still works after the abort
    apply("post_abort", 1'b0, 9'd254, 48'h9000_0000_0000, 1'b0, 32'h0);
    chk("post_abort_result", result, 32'h40100000);
    @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
